// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the iterative AES datapath: key-size mode
// encodings, round-number bounds and the round-register FSM state type.
// Also used by mixColumns so that both blocks agree on the final round.
// ----------------------------------------------------------------------------
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned ROUND_W = 5;
  localparam int unsigned MODE_W  = 2;

  // Key-size encodings; 2'h1 is not a distinct size and runs as AES-128.
  localparam logic [MODE_W-1:0] AES128 = 2'h0;
  localparam logic [MODE_W-1:0] AES192 = 2'h2;
  localparam logic [MODE_W-1:0] AES256 = 2'h3;

  // Round numbering starts at the whitening step rather than at zero.
  localparam logic [ROUND_W-1:0] START_ROUND = 5'h02;
  localparam logic [ROUND_W-1:0] LAST_128    = 5'h0C;
  localparam logic [ROUND_W-1:0] LAST_192    = 5'h0E;
  localparam logic [ROUND_W-1:0] LAST_256    = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'h0,
    ST_RUN  = 2'h1,
    ST_DONE = 2'h2
  } ark_state_e;

  // Final round value for a given key-size mode.
  function automatic logic [ROUND_W-1:0] last_round(input logic [MODE_W-1:0] m);
    case (m)
      AES192:  return LAST_192;
      AES256:  return LAST_256;
      default: return LAST_128;
    endcase
  endfunction

endpackage : aes_pkg

// File: rtl/add_round_key_reg.sv
// ----------------------------------------------------------------------------
// add_round_key_reg
// Iterative AES round register and round controller. XORs the round-function
// result with the current round key and registers it as the cipher state,
// applies the initial key whitening on load, and hands the ciphertext out
// through a valid/ready handshake once the final round is done.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      plaintext offered
//   in_ready      block can accept plaintext (registered)
//   data_in       plaintext, byte 0 in [127:120]
//   mode          key size, sampled on accept
//   round_key     round key for the current round, from the key schedule
//   key_valid     round_key valid for the current round; low stalls the round
//   rf_in         round-function result (mixColumns output)
//   state_out     registered cipher state, feeds subBytes
//   round         current round number, to mixColumns and the key schedule
//   mode_out      latched key-size mode
//   out_valid     ciphertext valid
//   out_ready     consumer accepts ciphertext
//   data_out      ciphertext, equal to state_out while out_valid
// ----------------------------------------------------------------------------
module add_round_key_reg
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BLOCK_W-1:0]   data_in,
  input  logic [MODE_W-1:0]    mode,
  input  logic [BLOCK_W-1:0]   round_key,
  input  logic                 key_valid,
  input  logic [BLOCK_W-1:0]   rf_in,
  output logic [BLOCK_W-1:0]   state_out,
  output logic [ROUND_W-1:0]   round,
  output logic [MODE_W-1:0]    mode_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BLOCK_W-1:0]   data_out
);

  ark_state_e           state_q,     state_d;
  logic [BLOCK_W-1:0]   blk_q,       blk_d;
  logic [ROUND_W-1:0]   round_q,     round_d;
  logic [MODE_W-1:0]    mode_q,      mode_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q,  in_ready_d;
  logic [BLOCK_W-1:0]   data_out_q,  data_out_d;

  // Next-state and next-output logic; every register holds unless updated.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    round_d     = round_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    data_out_d  = data_out_q;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        round_d    = START_ROUND;
        // A block is only taken when its whitening key is already available.
        if (in_valid && in_ready_q && key_valid) begin
          blk_d      = data_in ^ round_key;
          mode_d     = mode;
          round_d    = ROUND_W'(START_ROUND + 5'd1);
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end

      ST_RUN: begin
        in_ready_d = 1'b0;
        if (key_valid) begin
          blk_d = rf_in ^ round_key;
          // Final round: round number holds at LAST and the result is published.
          if (round_q == last_round(mode_q)) begin
            out_valid_d = 1'b1;
            data_out_d  = rf_in ^ round_key;
            state_d     = ST_DONE;
          end else begin
            round_d = ROUND_W'(round_q + 5'd1);
          end
        end
      end

      ST_DONE: begin
        in_ready_d = 1'b0;
        if (out_ready) begin
          out_valid_d = 1'b0;
          round_d     = START_ROUND;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        round_d     = START_ROUND;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      blk_q       <= '0;
      round_q     <= START_ROUND;
      mode_q      <= AES128;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      round_q     <= round_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      data_out_q  <= data_out_d;
    end
  end

  assign state_out = blk_q;
  assign round     = round_q;
  assign mode_out  = mode_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign data_out  = data_out_q;

endmodule : add_round_key_reg

// File: tb/tb_add_round_key_reg.sv
// ----------------------------------------------------------------------------
// tb_add_round_key_reg
// Directed bench for add_round_key_reg. A reference subBytes/shiftRows/
// mixColumns and key schedule close the loop around the DUT so complete
// FIPS-197 encryptions can be run; expected ciphertexts are queued on accept
// and compared when out_valid appears.
// ----------------------------------------------------------------------------
module tb_add_round_key_reg;

  typedef struct {
    logic [127:0] ct;
    int           lat;
    logic [4:0]   last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic [1:0]   mode = 2'h0;
  logic [127:0] round_key = '0;
  logic         key_valid = 1'b0;
  logic [127:0] rf_in = '0;
  logic [127:0] state_out;
  logic [4:0]   rnd;
  logic [1:0]   mode_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] data_out;

  // Bench-side configuration of the surrounding datapath.
  logic         loop_en  = 1'b0;
  logic [127:0] tb_key   = '0;
  logic [127:0] tb_rf    = '0;
  logic [4:0]   cur_last = 5'h0C;
  logic [127:0] cur_pt   = '0;
  logic [127:0] rk [0:14];
  logic [7:0]   sbox [0:255];

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  add_round_key_reg dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .mode      (mode),
    .round_key (round_key),
    .key_valid (key_valid),
    .rf_in     (rf_in),
    .state_out (state_out),
    .round     (rnd),
    .mode_out  (mode_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Reference subBytes + shiftRows (+ mixColumns unless final round).
  function automatic logic [127:0] aes_rnd(input logic [127:0] st, input logic fin);
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) s[i] = sbox[st[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) t[w+4*c] = s[w+4*((c+w)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] a0, a1, a2, a3;
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r;
  endfunction

  // Expected state after whitening plus k full rounds.
  function automatic logic [127:0] ref_partial(input int k);
    logic [127:0] s = cur_pt ^ rk[0];
    for (int j = 1; j <= k; j++) s = aes_rnd(s, 5'(j + 2) == cur_last) ^ rk[j];
    return s;
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nk + 6; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    cur_last = 5'(nk + 8);
  endtask

  // Models the key schedule and round function around the DUT.
  always @(negedge clk) begin
    if (loop_en) begin
      if (int'(rnd) >= 2 && int'(rnd) <= 16) round_key = rk[int'(rnd) - 2];
      rf_in = aes_rnd(state_out, rnd == cur_last);
    end else begin
      round_key = tb_key;
      rf_in     = tb_rf;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Accepts one block, optionally stalls key_valid for 3 cycles starting after
  // edge stall_at, then holds out_ready low for hold cycles before draining.
  task automatic run_block(input logic [127:0] pt, input logic [1:0] m,
                           input logic [127:0] ct, input int lat,
                           input logic [4:0] last, input int stall_at,
                           input int hold);
    exp_t e;
    exp_t g;
    int   cyc;
    cur_pt    = pt;
    data_in   = pt;
    mode      = m;
    in_valid  = 1'b1;
    key_valid = 1'b1;
    @(posedge clk); #1;
    e.ct = ct; e.lat = lat; e.last = last;
    sb.push_back(e);
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom, $urandom, $urandom};
    mode     = ~m;
    cyc      = 1;
    while (out_valid !== 1'b1 && cyc < 64) begin
      if (stall_at > 0 && cyc == stall_at)     key_valid = 1'b0;
      if (stall_at > 0 && cyc == stall_at + 3) key_valid = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (stall_at > 0 && cyc > stall_at && cyc <= stall_at + 3) begin
        chk("stall_round", 128'(rnd), 128'(stall_at + 2));
        chk("stall_state", state_out, ref_partial(stall_at - 1));
      end
    end
    key_valid = 1'b1;
    chk("out_valid_seen", 128'(out_valid), 128'(1));
    g = sb.pop_front();
    chk("latency", 128'(cyc), 128'(g.lat));
    chk("data_out", data_out, g.ct);
    chk("final_round", 128'(rnd), 128'(g.last));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk("hold_data_out", data_out, g.ct);
      chk("hold_in_ready", 128'(in_ready), 128'(0));
      chk("hold_out_valid", 128'(out_valid), 128'(1));
      chk("hold_round", 128'(rnd), 128'(g.last));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_out_valid", 128'(out_valid), 128'(0));
    chk("drain_in_ready", 128'(in_ready), 128'(1));
    chk("drain_round", 128'(rnd), 128'(5'h02));
  endtask

  initial begin
    int n;
    // Build the S-box from GF(2^8) inverses and the affine map.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s, r;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv; r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      sbox[x] = s ^ 8'h63;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_round", 128'(rnd), 128'(5'h02));
    chk("rst_state_out", state_out, '0);
    chk("rst_data_out", data_out, '0);
    chk("rst_mode_out", 128'(mode_out), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // No accept while the whitening key is not yet valid.
    tb_key    = 128'h000102030405060708090a0b0c0d0e0f;
    data_in   = PT;
    in_valid  = 1'b1;
    key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("nokey_in_ready", 128'(in_ready), 128'(1));
    chk("nokey_round", 128'(rnd), 128'(5'h02));
    chk("nokey_state", state_out, '0);

    // Whitening on accept.
    key_valid = 1'b1;
    mode      = 2'h3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("whiten_state", state_out, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("whiten_round", 128'(rnd), 128'(5'h03));
    chk("whiten_in_ready", 128'(in_ready), 128'(0));
    chk("whiten_mode_out", 128'(mode_out), 128'(3));
    pulse_reset();

    // AES-128 latency with zero round function and all-ones key.
    tb_rf  = '0;
    tb_key = '1;
    @(posedge clk); #1;
    run_block(128'h0123456789abcdef0123456789abcdef, 2'h0, '1, 11, 5'h0C, 0, 0);

    // FIPS-197 closed loop for each key size.
    loop_en = 1'b1;
    expand(KEY256, 4);
    run_block(PT, 2'h0, CT128, 11, 5'h0C, 0, 0);
    expand(KEY256, 6);
    run_block(PT, 2'h2, CT192, 13, 5'h0E, 0, 0);
    expand(KEY256, 8);
    run_block(PT, 2'h3, CT256, 15, 5'h10, 0, 0);

    // Key stall mid-run, then output back-pressure.
    expand(KEY256, 4);
    run_block(PT, 2'h0, CT128, 14, 5'h0C, 5, 0);
    run_block(PT, 2'h0, CT128, 11, 5'h0C, 0, 5);

    // Reset mid-run at round 7 discards the block.
    data_in   = PT;
    mode      = 2'h0;
    in_valid  = 1'b1;
    key_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (rnd !== 5'h07 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_round7", 128'(rnd), 128'(5'h07));
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_round", 128'(rnd), 128'(5'h02));
    chk("midrst_state", state_out, '0);
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", 128'(out_valid), 128'(0));
    end
    run_block(PT, 2'h0, CT128, 11, 5'h0C, 0, 0);

    // Mode 1 runs as AES-128.
    run_block(PT, 2'h1, CT128, 11, 5'h0C, 0, 0);
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_add_round_key_reg
